mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_iter.sv | 206 ++++++++++++++++++++
 tb/tb_mdu_iter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit. It does one radix-2 step per clock.
//
// Operations:
//   MULH / MULHU  high word of the 64-bit product (signed / unsigned)
//   MULW          low word of the signed product; OV set if the product does
//                 not fit in 32 signed bits
//   DIVW / DIVWU  quotient truncated toward zero (signed / unsigned);
//                 divide by zero and signed overflow return C=0 with OV=1
//
// Ports:
//   clk     clock; all state changes on the rising edge
//   rst_n   asynchronous active-low reset
//   A, B    operands (bit 0 is the MSB)
//   Op      operation select
//   start   request; A/B/Op are captured when accepted in IDLE or DONE
//   cancel  abort the operation in flight (RUN or FIX) with no done pulse
//   busy    high while in RUN or FIX
//   done    one-cycle result-valid pulse
//   C       result register
//   D       {OV, LT, GT, EQ}; the last three are CR0 of C read as signed
//
// Latency: start at edge t -> busy for cycles t+1..t+33 -> done at t+34.
// Optional macro MDU_EARLY_OUT_EN: a multiply with a zero operand, or a
// divide with B=0, skips RUN and raises done at t+2. Results are the same.

`ifndef ARCH_WIDTH
`define ARCH_WIDTH 32
`endif
`ifndef MDUOp_WIDTH
`define MDUOp_WIDTH 3
`endif
`ifndef MDU_D_WIDTH
`define MDU_D_WIDTH 4
`endif
`ifndef MDUOp_MULH
`define MDUOp_MULH  3'd1
`define MDUOp_MULHU 3'd2
`define MDUOp_MULW  3'd3
`define MDUOp_DIVW  3'd4
`define MDUOp_DIVWU 3'd5
`endif

module mdu_iter (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [0:`ARCH_WIDTH-1]  A,
  input  logic [0:`ARCH_WIDTH-1]  B,
  input  logic [0:`MDUOp_WIDTH-1] Op,
  input  logic                    start,
  input  logic                    cancel,
  output logic                    busy,
  output logic                    done,
  output logic [0:`ARCH_WIDTH-1]  C,
  output logic [0:`MDU_D_WIDTH-1] D
);
  localparam int W = `ARCH_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_next;

  // Descending-order views of the MSB-first ports.
  logic [W-1:0]            a_val, b_val;
  logic [`MDUOp_WIDTH-1:0] op_in;
  assign a_val = A;
  assign b_val = B;
  assign op_in = Op;

  // Decoding of the incoming request.
  logic         is_mul_in, is_div_in, signed_in, accept, early;
  logic [W-1:0] a_mag, b_mag;
  assign is_mul_in = (op_in == `MDUOp_MULH) || (op_in == `MDUOp_MULHU) || (op_in == `MDUOp_MULW);
  assign is_div_in = (op_in == `MDUOp_DIVW) || (op_in == `MDUOp_DIVWU);
  assign signed_in = (op_in == `MDUOp_MULH) || (op_in == `MDUOp_MULW) || (op_in == `MDUOp_DIVW);
  assign a_mag     = (signed_in && a_val[W-1]) ? -a_val : a_val;
  assign b_mag     = (signed_in && b_val[W-1]) ? -b_val : b_val;
  assign accept    = start && ((state == IDLE) || (state == DONE));
`ifdef MDU_EARLY_OUT_EN
  assign early = (is_mul_in && ((a_val == '0) || (b_val == '0))) || (is_div_in && (b_val == '0));
`else
  assign early = 1'b0;
`endif

  // Iteration registers. hi:lo is the product accumulator during a multiply.
  // During a divide, hi is the partial remainder and lo shifts the dividend
  // out and the quotient in.
  logic [4:0]              cnt;
  logic [W-1:0]            hi, lo, opnd;
  logic [`MDUOp_WIDTH-1:0] op_reg;
  logic                    neg, div_special, is_div_reg;
  logic [W-1:0]            c_reg;
  logic [3:0]              d_reg;
  assign is_div_reg = (op_reg == `MDUOp_DIVW) || (op_reg == `MDUOp_DIVWU);

  // Shift-add multiply step: conditionally add multiplicand, shift right.
  logic [W:0] add_sum;
  assign add_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});

  // Restoring divide step: shift in next dividend bit, subtract if it fits.
  logic [W:0] shifted, diff;
  logic       borrow;
  assign shifted = {hi, lo[W-1]};
  assign diff    = shifted - {1'b0, opnd};
  assign borrow  = shifted < {1'b0, opnd};

  // Sign correction and result selection, used in FIX.
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo_s, res;
  logic           res_ov;
  assign prod_s = neg ? -{hi, lo} : {hi, lo};
  assign quo_s  = neg ? -lo : lo;

  always_comb begin
    res    = '0;
    res_ov = 1'b0;
    case (op_reg)
      `MDUOp_MULH, `MDUOp_MULHU: res = prod_s[2*W-1:W];
      `MDUOp_MULW: begin
        res    = prod_s[W-1:0];
        res_ov = prod_s[2*W-1:W] != {W{prod_s[W-1]}};
      end
      `MDUOp_DIVW, `MDUOp_DIVWU: begin
        res    = div_special ? '0 : quo_s;
        res_ov = div_special;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = early ? FIX : RUN;
      RUN: begin
        busy = 1'b1;
        if (cancel)              state_next = IDLE;
        else if (cnt == 5'd31)   state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = cancel ? IDLE : DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? (early ? FIX : RUN) : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      opnd        <= '0;
      op_reg      <= '0;
      neg         <= 1'b0;
      div_special <= 1'b0;
      c_reg       <= '0;
      d_reg       <= '0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        hi     <= '0;
        op_reg <= op_in;
        neg    <= signed_in && (a_val[W-1] ^ b_val[W-1]);
        if (is_div_in) begin
          opnd <= b_mag;
          lo   <= a_mag;
        end else begin
          opnd <= a_mag;
          // A zero multiplicand must give an all-zero accumulator even if
          // the iterations are skipped.
          lo   <= (a_val == '0) ? '0 : b_mag;
        end
        div_special <= is_div_in && ((b_val == '0) ||
                       ((op_in == `MDUOp_DIVW) && (a_val == {1'b1, {(W-1){1'b0}}}) &&
                        (b_val == {W{1'b1}})));
      end else if (state == RUN) begin
        cnt <= cnt + 5'd1;
        if (is_div_reg) begin
          hi <= borrow ? shifted[W-1:0] : diff[W-1:0];
          lo <= {lo[W-2:0], ~borrow};
        end else begin
          hi <= add_sum[W:1];
          lo <= {add_sum[0], lo[W-1:1]};
        end
      end
      if ((state == FIX) && !cancel) begin
        c_reg <= res;
        d_reg <= {res_ov, res[W-1], ~res[W-1] && (res != '0), res == '0};
      end
    end
  end

  assign C = c_reg;
  assign D = d_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases, cancel, ignored
// start, back-to-back start, mid-operation reset, then random operations
// compared against an arithmetic reference model.

`ifndef ARCH_WIDTH
`define ARCH_WIDTH 32
`endif
`ifndef MDUOp_WIDTH
`define MDUOp_WIDTH 3
`endif
`ifndef MDU_D_WIDTH
`define MDU_D_WIDTH 4
`endif
`ifndef MDUOp_MULH
`define MDUOp_MULH  3'd1
`define MDUOp_MULHU 3'd2
`define MDUOp_MULW  3'd3
`define MDUOp_DIVW  3'd4
`define MDUOp_DIVWU 3'd5
`endif

module tb_mdu_iter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B;
  logic [2:0]  Op;
  logic        start, cancel;
  logic        busy, done;
  logic [31:0] C;
  logic [3:0]  D;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_iter dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Op(Op),
    .start(start), .cancel(cancel), .busy(busy), .done(done), .C(C), .D(D)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural values.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] c, output logic [3:0] d);
    longint      sa, sb, sp, sq;
    logic [63:0] p;
    logic        ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = '0;
    ov = 1'b0;
    case (op)
      `MDUOp_MULH: begin
        sp = sa * sb;
        p  = sp;
        c  = p[63:32];
      end
      `MDUOp_MULHU: begin
        p = {32'd0, a} * {32'd0, b};
        c = p[63:32];
      end
      `MDUOp_MULW: begin
        sp = sa * sb;
        p  = sp;
        c  = p[31:0];
        ov = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
      end
      `MDUOp_DIVW: begin
        if (b == 0 || (a == 32'h80000000 && b == 32'hFFFFFFFF)) ov = 1'b1;
        else begin
          sq = sa / sb;
          p  = sq;
          c  = p[31:0];
        end
      end
      `MDUOp_DIVWU: begin
        if (b == 0) ov = 1'b1;
        else c = a / b;
      end
      default: ;
    endcase
    d = {ov, c[31], (!c[31]) && (c != 0), c == 0};
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit is_mul, is_div;
    is_mul = (op == `MDUOp_MULH) || (op == `MDUOp_MULHU) || (op == `MDUOp_MULW);
    is_div = (op == `MDUOp_DIVW) || (op == `MDUOp_DIVWU);
`ifdef MDU_EARLY_OUT_EN
    if ((is_mul && (a == 0 || b == 0)) || (is_div && b == 0)) return 2;
`endif
    return 34;
  endfunction

  // Drive a request for one cycle; returns at the falling edge of cycle t+1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A = a; B = b; Op = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; lat starts at the cycle index we are in.
  task automatic wait_done(input int lat0, output int lat, output int busy_bad);
    lat = lat0;
    busy_bad = 0;
    while (!done && lat < 80) begin
      if (!busy) busy_bad++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ec, input logic [3:0] ed);
    int lat, bb;
    issue(op, a, b);
    wait_done(1, lat, bb);
    check("latency", lat, exp_lat(op, a, b));
    check("busy_while_running", bb, 0);
    check("busy_with_done", busy, 0);
    check("C", C, ec);
    check("D", D, ed);
    $display("op=%0d A=%h B=%h -> C=%h D=%b lat=%0d", op, a, b, C, D, lat);
    @(negedge clk);
    check("done_single_pulse", done, 0);
  endtask

  initial begin
    logic [31:0] ec, pc, a, b;
    logic [3:0]  ed, pd;
    logic [2:0]  op;
    int          lat, bb, seen;

    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; A = '0; B = '0; Op = '0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_C", C, 0);
    check("reset_D", D, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases.
    run_op(`MDUOp_MULW,  32'h00010000, 32'h00010000, 32'h00000000, 4'b1001);
    run_op(`MDUOp_MULH,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 4'b0100);
    run_op(`MDUOp_MULHU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 4'b0010);
    run_op(`MDUOp_DIVW,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 4'b0100);
    run_op(`MDUOp_DIVWU, 32'h00000007, 32'h00000002, 32'h00000003, 4'b0010);
    run_op(`MDUOp_DIVWU, 32'h00000007, 32'h00000000, 32'h00000000, 4'b1001);
    run_op(`MDUOp_DIVW,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b1001);
    run_op(3'd7,         32'h12345678, 32'h00000003, 32'h00000000, 4'b0001);

    // Cancel during RUN at t+10: no done, C/D retained.
    run_op(`MDUOp_MULHU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 4'b0010);
    pc = C; pd = D;
    issue(`MDUOp_DIVWU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    seen = 0;
    repeat (40) begin
      if (done) seen = 1;
      @(negedge clk);
    end
    check("cancel_no_done", seen, 0);
    check("cancel_C_kept", C, pc);
    check("cancel_D_kept", D, pd);
    $display("cancel: C=%h D=%b", C, D);

    // Start at t+5 while busy is ignored.
    issue(`MDUOp_MULW, 32'h00010000, 32'h00010000);
    repeat (4) @(negedge clk);
    A = 32'd5; B = 32'd3; Op = `MDUOp_DIVWU; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, lat, bb);
    check("ignored_start_lat", lat, 34);
    check("ignored_start_C", C, 32'h0);
    check("ignored_start_D", D, 4'b1001);
    @(negedge clk);
    check("ignored_start_not_queued", busy, 0);
    $display("ignored start: C=%h D=%b lat=%0d", C, D, lat);

    // Start in DONE: back-to-back results 34 cycles apart.
    issue(`MDUOp_DIVW, 32'hFFFFFFF9, 32'h00000002);
    wait_done(1, lat, bb);
    check("b2b_first_C", C, 32'hFFFFFFFD);
    A = 32'd7; B = 32'd2; Op = `MDUOp_DIVWU; start = 1'b1;
    check("b2b_busy_in_done", busy, 0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_after", busy, 1);
    wait_done(1, lat, bb);
    check("b2b_spacing", lat, 34);
    check("b2b_second_C", C, 32'h3);
    check("b2b_second_D", D, 4'b0010);
    $display("back-to-back: C=%h D=%b spacing=%0d", C, D, lat);
    @(negedge clk);

    // Reset at t+20 clears outputs immediately and suppresses done.
    issue(`MDUOp_MULH, 32'h7FFFFFFF, 32'h7FFFFFFF);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_C", C, 0);
    check("rst_D", D, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      if (done) seen = 1;
      @(negedge clk);
    end
    check("rst_no_done", seen, 0);
    $display("mid-op reset: C=%h D=%b", C, D);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = 32'h0;
        1: a = 32'h80000000;
        2: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      model(op, a, b, ec, ed);
      run_op(op, a, b, ec, ed);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
